bus_bridge: RTL and testbench

Address-decoding bridge that sits directly downstream of the CPU's MEM-stage bus port (Bus_addr/Bus_wen/Bus_wdata/Bus_rdata).
- Routes each access either to the data RAM or to the on-board peripheral page at 0xFFFF_F000–0xFFFF_FFFF.
- Owns the peripheral state: LED register, 8-digit seven-segment display register plus scan engine, synchronised buttons, and an optional cycle timer.
- Read path is combinational so the CPU captures read data in the same cycle as the access.

---
 rtl/bus_bridge_if.sv | 23 ++
 rtl/bus_bridge.sv | 164 ++++++++++++++++
 tb/tb_bus_bridge.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/bus_bridge_if.sv
// CPU MEM-stage bus port carried between the CPU and the bus_bridge.
interface bus_bridge_if;
  logic [31:0] Bus_addr;
  logic        Bus_wen;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata;

  // CPU side drives the access and receives load data
  modport master (
    output Bus_addr,
    output Bus_wen,
    output Bus_wdata,
    input  Bus_rdata
  );

  // Bridge side decodes the access and returns load data
  modport slave (
    input  Bus_addr,
    input  Bus_wen,
    input  Bus_wdata,
    output Bus_rdata
  );
endinterface

// File: rtl/bus_bridge.sv
// Address-decoding bridge between the CPU bus, the data RAM and the peripheral
// page at 0xFFFF_F000. It owns the LED, seven-segment and button state.
// The optional cycle timer at 0xFFFF_F020 is built only when BRIDGE_TIMER_EN is
// defined; otherwise that address behaves as unmapped.
module bus_bridge #(
  parameter int unsigned DRAM_AW  = 14,
  parameter int unsigned SCAN_DIV = 2000
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst_n,
  bus_bridge_if.slave        bus,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_wen,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  input  logic [4:0]         btn,
  output logic [23:0]        led,
  output logic [7:0]         dig_en,
  output logic [7:0]         dig_seg
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  localparam logic [11:0] OFS_DIG   = 12'h000;
  localparam logic [11:0] OFS_TIMER = 12'h020;
  localparam logic [11:0] OFS_LED   = 12'h060;
  localparam logic [11:0] OFS_SW    = 12'h070;
  localparam logic [11:0] OFS_BTN   = 12'h078;

  logic        periph;
  logic [11:0] ofs;
  logic        sel_dig;
  logic        sel_led;
  logic        sel_sw;
  logic        sel_btn;
  logic        sel_timer;
  logic [31:0] digit_reg;
  logic [4:0]  btn_meta;
  logic [4:0]  btn_sync;
  logic [DIV_W-1:0] div;
  logic [2:0]  idx;
  logic [31:0] timer_val;
  logic [31:0] rdata;

  // Active-low segment pattern for one hex digit, decimal point off
  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Address decode
  assign periph  = (bus.Bus_addr[31:12] == 20'hFFFFF);
  assign ofs     = bus.Bus_addr[11:0];
  assign sel_dig = periph && (ofs == OFS_DIG);
  assign sel_led = periph && (ofs == OFS_LED);
  assign sel_sw  = periph && (ofs == OFS_SW);
  assign sel_btn = periph && (ofs == OFS_BTN);

  // DRAM path; peripheral stores never reach the RAM
  assign dram_addr  = bus.Bus_addr[DRAM_AW+1:2];
  assign dram_wen   = bus.Bus_wen & ~periph;
  assign dram_wdata = bus.Bus_wdata;

`ifdef BRIDGE_TIMER_EN
  logic [31:0] timer;

  assign sel_timer = periph && (ofs == OFS_TIMER);
  assign timer_val = timer;

  // Free-running cycle timer; a store loads it instead of incrementing
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      timer <= '0;
    end else if (bus.Bus_wen && sel_timer) begin
      timer <= bus.Bus_wdata;
    end else begin
      timer <= timer + 32'd1;
    end
  end
`else
  assign sel_timer = 1'b0;
  assign timer_val = '0;
`endif

  // Combinational load mux so the CPU captures data in the access cycle
  always_comb begin
    rdata = '0;
    if (!periph)        rdata = dram_rdata;
    else if (sel_dig)   rdata = digit_reg;
    else if (sel_led)   rdata = {8'b0, led};
    else if (sel_sw)    rdata = {8'b0, sw};
    else if (sel_btn)   rdata = {27'b0, btn_sync};
    else if (sel_timer) rdata = timer_val;
  end

  assign bus.Bus_rdata = rdata;

  // Writable peripheral registers
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      led       <= '0;
      digit_reg <= '0;
    end else if (bus.Bus_wen) begin
      if (sel_led) led       <= bus.Bus_wdata[23:0];
      if (sel_dig) digit_reg <= bus.Bus_wdata;
    end
  end

  // Two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

  // Scan timing: hold each digit SCAN_DIV cycles, then advance to the next
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
      idx <= idx + 3'd1;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Registered display drive for the digit currently selected by idx
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      dig_en  <= 8'hFF;
      dig_seg <= 8'hFF;
    end else begin
      dig_en  <= ~(8'b1 << idx);
      dig_seg <= hex7(digit_reg[{idx, 2'b00} +: 4]);
    end
  end

endmodule

// File: tb/tb_bus_bridge.sv
// Directed testbench for bus_bridge (scan divider shortened to 4 cycles).
module tb_bus_bridge;

  localparam int unsigned DRAM_AW  = 14;
  localparam int unsigned SCAN_DIV = 4;

  logic               clk;
  logic               rst_n;
  logic [DRAM_AW-1:0] dram_addr;
  logic               dram_wen;
  logic [31:0]        dram_wdata;
  logic [31:0]        dram_rdata;
  logic [23:0]        sw;
  logic [4:0]         btn;
  logic [23:0]        led;
  logic [7:0]         dig_en;
  logic [7:0]         dig_seg;
  logic [31:0]        mem [16];

  int checks = 0;
  int errors = 0;

  bus_bridge_if bus ();

  bus_bridge #(.DRAM_AW(DRAM_AW), .SCAN_DIV(SCAN_DIV)) dut (
    .cpu_clk   (clk),
    .cpu_rst_n (rst_n),
    .bus       (bus.slave),
    .dram_addr (dram_addr),
    .dram_wen  (dram_wen),
    .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata),
    .sw        (sw),
    .btn       (btn),
    .led       (led),
    .dig_en    (dig_en),
    .dig_seg   (dig_seg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Small combinational RAM standing in for the data memory
  always @(posedge clk) begin
    if (dram_wen) mem[dram_addr[3:0]] <= dram_wdata;
  end
  assign dram_rdata = mem[dram_addr[3:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] n);
    logic [7:0] tbl [16];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return tbl[n];
  endfunction

  task automatic bus_set(input logic [31:0] a, input logic w, input logic [31:0] d);
    bus.Bus_addr  = a;
    bus.Bus_wen   = w;
    bus.Bus_wdata = d;
  endtask

  initial begin
    logic [31:0] digits;
    int          di;
    logic [7:0]  exp_en;
    logic [7:0]  exp_seg;

    rst_n = 1'b0;
    sw    = '0;
    btn   = '0;
    bus_set(32'h0, 1'b0, 32'h0);

    // Reset, then store to DIG in the cycle before the first edge after release
    @(negedge clk);
    @(negedge clk);
    check("rst_led", 32'(led), 32'h0);
    check("rst_dig_en", 32'(dig_en), 32'hFF);
    check("rst_dig_seg", 32'(dig_seg), 32'hFF);
    rst_n = 1'b1;
    digits = 32'h0000_00F8;
    bus_set(32'hFFFF_F000, 1'b1, digits);
    #1 check("dig_wr_no_dram", 32'(dram_wen), 32'h0);

    // Scan: edge k shows idx ((k-1)/4)%8; edge 1 still sees the old digits
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      bus_set(32'hFFFF_F000, 1'b0, 32'h0);
      di      = ((k - 1) / 4) % 8;
      exp_en  = ~(8'b1 << di);
      exp_seg = (k == 1) ? 8'hC0 : seg_of(4'((digits >> (4 * di)) & 32'hF));
      check($sformatf("scan_en_e%0d", k), 32'(dig_en), 32'(exp_en));
      check($sformatf("scan_seg_e%0d", k), 32'(dig_seg), 32'(exp_seg));
    end
    #1 check("dig_rd", bus.Bus_rdata, 32'h0000_00F8);

    // DRAM store then load
    @(negedge clk);
    bus_set(32'h0000_0010, 1'b1, 32'h1234_5678);
    #1;
    check("dram_wen_st", 32'(dram_wen), 32'h1);
    check("dram_addr", 32'(dram_addr), 32'h4);
    check("dram_wdata", dram_wdata, 32'h1234_5678);
    @(negedge clk);
    bus_set(32'h0000_0010, 1'b0, 32'h0);
    #1;
    check("dram_wen_ld", 32'(dram_wen), 32'h0);
    check("dram_ld", bus.Bus_rdata, 32'h1234_5678);

    // LED store, readback, and ignored store to read-only SW
    @(negedge clk);
    bus_set(32'hFFFF_F060, 1'b1, 32'h00AB_CDEF);
    #1 check("led_st_no_dram", 32'(dram_wen), 32'h0);
    @(negedge clk);
    bus_set(32'hFFFF_F060, 1'b0, 32'h0);
    #1;
    check("led_val", 32'(led), 32'h00AB_CDEF);
    check("led_rd", bus.Bus_rdata, 32'h00AB_CDEF);
    @(negedge clk);
    bus_set(32'hFFFF_F070, 1'b1, 32'hFFFF_FFFF);
    #1 check("sw_st_no_dram", 32'(dram_wen), 32'h0);
    @(negedge clk);
    bus_set(32'hFFFF_F060, 1'b0, 32'h0);
    #1;
    check("led_kept", 32'(led), 32'h00AB_CDEF);
    check("led_rd_kept", bus.Bus_rdata, 32'h00AB_CDEF);
    bus_set(32'hFFFF_F004, 1'b0, 32'h0);
    #1 check("unmapped_rd", bus.Bus_rdata, 32'h0);

    // Switches and synchronised buttons
    @(negedge clk);
    sw = 24'h00_F00F;
    bus_set(32'hFFFF_F070, 1'b0, 32'h0);
    #1 check("sw_rd", bus.Bus_rdata, 32'h0000_F00F);
    btn = 5'b10001;
    bus_set(32'hFFFF_F078, 1'b0, 32'h0);
    #1 check("btn_e0", bus.Bus_rdata, 32'h0);
    @(negedge clk);
    check("btn_e1", bus.Bus_rdata, 32'h0);
    @(negedge clk);
    check("btn_e2", bus.Bus_rdata, 32'h11);

    // Timer load and wrap
    @(negedge clk);
    bus_set(32'hFFFF_F020, 1'b1, 32'hFFFF_FFFE);
    @(negedge clk);
    bus_set(32'hFFFF_F020, 1'b0, 32'h0);
    @(negedge clk);
`ifdef BRIDGE_TIMER_EN
    check("timer_0", bus.Bus_rdata, 32'hFFFF_FFFF);
    @(negedge clk);
    check("timer_1", bus.Bus_rdata, 32'h0000_0000);
    @(negedge clk);
    check("timer_2", bus.Bus_rdata, 32'h0000_0001);
`else
    check("timer_off_0", bus.Bus_rdata, 32'h0);
    @(negedge clk);
    check("timer_off_1", bus.Bus_rdata, 32'h0);
`endif

    // Asynchronous reset mid-scan with all LEDs lit
    @(negedge clk);
    bus_set(32'hFFFF_F060, 1'b1, 32'h00FF_FFFF);
    @(negedge clk);
    bus_set(32'hFFFF_F060, 1'b0, 32'h0);
    #1 check("led_full", 32'(led), 32'h00FF_FFFF);
    #2 rst_n = 1'b0;
    #1;
    check("arst_led", 32'(led), 32'h0);
    check("arst_dig_en", 32'(dig_en), 32'hFF);
    check("arst_dig_seg", 32'(dig_seg), 32'hFF);
    check("arst_led_rd", bus.Bus_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_dig_en", 32'(dig_en), 32'hFE);
    check("rel_dig_seg", 32'(dig_seg), 32'hC0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
